// File: rtl/alu_cmd_issuer_if.sv
// Command, arithmetic-unit and response signals of the ALU command issuer.
// The master modport is the issuer's side; the slave modport is the command source, unit and consumer.
interface alu_cmd_issuer_if;
    logic       Cmd_Valid;
    logic       Cmd_Ready;
    logic [3:0] Cmd_Op;
    logic [7:0] Cmd_A;
    logic [7:0] Cmd_B;
    logic [3:0] Alu_Op;
    logic [7:0] Alu_In1;
    logic [7:0] Alu_In2;
    logic [7:0] Alu_Out;
    logic       Rsp_Valid;
    logic       Rsp_Ready;
    logic [7:0] Rsp_Data;
    logic [3:0] Rsp_Op;
    logic       Rsp_Err;

    modport master (
        input  Cmd_Valid, Cmd_Op, Cmd_A, Cmd_B, Alu_Out, Rsp_Ready,
        output Cmd_Ready, Alu_Op, Alu_In1, Alu_In2, Rsp_Valid, Rsp_Data, Rsp_Op, Rsp_Err
    );

    modport slave (
        output Cmd_Valid, Cmd_Op, Cmd_A, Cmd_B, Alu_Out, Rsp_Ready,
        input  Cmd_Ready, Alu_Op, Alu_In1, Alu_In2, Rsp_Valid, Rsp_Data, Rsp_Op, Rsp_Err
    );
endinterface

// File: rtl/alu_cmd_issuer.sv
// Buffers arithmetic commands, issues them one at a time to an external combinational unit,
// and returns registered results in order; divide-by-zero is trapped locally.
module alu_cmd_issuer #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned ALU_LAT = 1
) (
    input  logic                Clk,
    input  logic                Rst,
    alu_cmd_issuer_if.master    bus,
    output logic [15:0]         Op_Count
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CNTW = AW + 1;
    localparam int unsigned WW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
    localparam logic [3:0] OP_DIV = 4'b0100;

    typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_e;

    typedef struct packed {
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
    } cmd_t;

    cmd_t            mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNTW-1:0] count_q, count_d, count_vis_q;
    state_e          state_q, state_d;
    logic [WW-1:0]   wait_q, wait_d;
    logic [3:0]      alu_op_q, alu_op_d;
    logic [7:0]      alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [7:0]      rsp_data_q, rsp_data_d;
    logic [3:0]      rsp_op_q, rsp_op_d;
    logic            rsp_err_q, rsp_err_d;
    logic [15:0]     op_count_q, op_count_d;
    logic            full_c, push_c, pop_c;
    cmd_t            head_c, cmd_in_c;

    assign full_c   = (count_q == CNTW'(DEPTH));
    assign push_c   = bus.Cmd_Valid && !full_c;
    assign head_c   = mem_q[rd_ptr_q];
    assign cmd_in_c = '{op: bus.Cmd_Op, a: bus.Cmd_A, b: bus.Cmd_B};

    // Next-state and output logic; a written entry becomes visible to the FSM one cycle after its push.
    always_comb begin
        state_d     = state_q;
        wait_d      = wait_q;
        alu_op_d    = alu_op_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_op_d    = rsp_op_q;
        rsp_err_d   = rsp_err_q;
        op_count_d  = op_count_q;
        pop_c       = 1'b0;

        case (state_q)
            IDLE: begin
                if ((count_q != '0) && (count_vis_q != '0)) begin
                    pop_c = 1'b1;
                    if ((head_c.op == OP_DIV) && (head_c.b == 8'h00)) begin
                        rsp_data_d  = 8'hFF;
                        rsp_err_d   = 1'b1;
                        rsp_op_d    = OP_DIV;
                        rsp_valid_d = 1'b1;
                        state_d     = HOLD;
                    end else begin
                        alu_op_d = head_c.op;
                        alu_a_d  = head_c.a;
                        alu_b_d  = head_c.b;
                        wait_d   = WW'(ALU_LAT - 1);
                        state_d  = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (wait_q == '0) begin
                    rsp_data_d  = bus.Alu_Out;
                    rsp_op_d    = alu_op_q;
                    rsp_err_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = HOLD;
                end else begin
                    wait_d = wait_q - WW'(1);
                end
            end
            HOLD: begin
                if (bus.Rsp_Ready) begin
                    rsp_valid_d = 1'b0;
                    op_count_d  = op_count_q + 16'd1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        wr_ptr_d = push_c ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop_c  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        case ({push_c, pop_c})
            2'b10:   count_d = count_q + CNTW'(1);
            2'b01:   count_d = count_q - CNTW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q     <= IDLE;
            wait_q      <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            count_vis_q <= '0;
            alu_op_q    <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_op_q    <= '0;
            rsp_err_q   <= 1'b0;
            op_count_q  <= '0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            count_vis_q <= count_q;
            alu_op_q    <= alu_op_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_op_q    <= rsp_op_d;
            rsp_err_q   <= rsp_err_d;
            op_count_q  <= op_count_d;
        end
    end

    // Payload storage needs no reset; occupancy is tracked by the pointers and count.
    always_ff @(posedge Clk) begin
        if (push_c) begin
            mem_q[wr_ptr_q] <= cmd_in_c;
        end
    end

    assign bus.Cmd_Ready = !full_c;
    assign bus.Alu_Op    = alu_op_q;
    assign bus.Alu_In1   = alu_a_q;
    assign bus.Alu_In2   = alu_b_q;
    assign bus.Rsp_Valid = rsp_valid_q;
    assign bus.Rsp_Data  = rsp_data_q;
    assign bus.Rsp_Op    = rsp_op_q;
    assign bus.Rsp_Err   = rsp_err_q;
    assign Op_Count      = op_count_q;
endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Scoreboard bench for alu_cmd_issuer: directed commands push expected results, a monitor
// pops and compares on every response handshake.
module tb_alu_cmd_issuer;
    logic        Clk = 1'b0;
    logic        Rst;
    logic [15:0] op_count;

    alu_cmd_issuer_if bus();

    alu_cmd_issuer #(.DEPTH(4), .ALU_LAT(1)) dut (
        .Clk      (Clk),
        .Rst      (Rst),
        .bus      (bus),
        .Op_Count (op_count)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic [7:0] data;
        logic [3:0] op;
        logic       err;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0h required %0h", name, got, want);
    endtask

    // External combinational arithmetic unit; unknown opcodes return In1 ^ In2.
    logic [15:0] prod;
    always_comb begin
        prod = 16'(bus.Alu_In1) * 16'(bus.Alu_In2);
        case (bus.Alu_Op)
            4'b0001: bus.Alu_Out = bus.Alu_In1 + bus.Alu_In2;
            4'b0010: bus.Alu_Out = bus.Alu_In1 - bus.Alu_In2;
            4'b0011: bus.Alu_Out = prod[7:0];
            4'b0100: bus.Alu_Out = (bus.Alu_In2 == 8'h00) ? 8'hFF : bus.Alu_In1 / bus.Alu_In2;
            default: bus.Alu_Out = bus.Alu_In1 ^ bus.Alu_In2;
        endcase
    end

    // Monitor: compare each accepted response against the head of the scoreboard.
    always @(negedge Clk) begin
        exp_t e;
        if (!Rst && bus.Rsp_Valid === 1'b1 && bus.Rsp_Ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                $display("FAIL stray_rsp: got data %0h op %0h err %0b, required no response",
                         bus.Rsp_Data, bus.Rsp_Op, bus.Rsp_Err);
            end else begin
                e = exp_q.pop_front();
                check("rsp{data,op,err}", 32'({bus.Rsp_Data, bus.Rsp_Op, bus.Rsp_Err}), 32'(e));
            end
        end
    end

    task automatic push(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] d, input logic err, input bit track);
        bit rdy;
        int n;
        n = 0;
        bus.Cmd_Valid = 1'b1;
        bus.Cmd_Op    = op;
        bus.Cmd_A     = a;
        bus.Cmd_B     = b;
        do begin
            @(negedge Clk);
            rdy = bus.Cmd_Ready;
            @(posedge Clk);
            #1;
            n++;
        end while (!rdy && n < 50);
        bus.Cmd_Valid = 1'b0;
        if (!rdy) begin
            n_chk++;
            $display("FAIL push_timeout: got Cmd_Ready 0 for %0d cycles, required acceptance", n);
        end else if (track) begin
            exp_q.push_back('{d, op, err});
        end
    endtask

    task automatic rsp_latency(output int lat);
        lat = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge Clk);
            if (bus.Rsp_Valid === 1'b1) break;
            @(posedge Clk);
            #1;
            lat++;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge Clk);
            n++;
        end
        #1;
        if (exp_q.size() != 0) begin
            n_chk++;
            $display("FAIL drain_timeout: got %0d responses outstanding, required 0", exp_q.size());
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat;
        int stray;
        Rst           = 1'b1;
        bus.Cmd_Valid = 1'b0;
        bus.Cmd_Op    = '0;
        bus.Cmd_A     = '0;
        bus.Cmd_B     = '0;
        bus.Rsp_Ready = 1'b1;

        repeat (2) @(posedge Clk);
        @(negedge Clk);
        check("reset_cmd_ready", 32'(bus.Cmd_Ready), 32'd1);
        check("reset_rsp_valid", 32'(bus.Rsp_Valid), 32'd0);
        check("reset_rsp_data",  32'({bus.Rsp_Data, bus.Rsp_Op, bus.Rsp_Err}), 32'd0);
        check("reset_alu",       32'({bus.Alu_Op, bus.Alu_In1, bus.Alu_In2}), 32'd0);
        check("reset_op_count",  32'(op_count), 32'd0);
        @(posedge Clk);
        #1 Rst = 1'b0;

        // Single add and its latency.
        push(4'b0001, 8'h03, 8'h09, 8'h0C, 1'b0, 1'b1);
        rsp_latency(lat);
        check("add_latency", 32'(lat), 32'd3);
        check("add_alu", 32'({bus.Alu_Op, bus.Alu_In1, bus.Alu_In2}), 32'h1_03_09);
        drain();
        check("op_count_1", 32'(op_count), 32'd1);

        // Back-to-back ordering.
        push(4'b0010, 8'h05, 8'h07, 8'hFE, 1'b0, 1'b1);
        push(4'b0011, 8'h10, 8'h10, 8'h00, 1'b0, 1'b1);
        push(4'b0100, 8'h09, 8'h02, 8'h04, 1'b0, 1'b1);
        drain();
        check("op_count_4", 32'(op_count), 32'd4);

        // Unknown opcode passes through.
        push(4'b1111, 8'h12, 8'h34, 8'h26, 1'b0, 1'b1);
        drain();

        // Divide by zero: trapped, faster, Alu_* untouched.
        push(4'b0100, 8'h2A, 8'h00, 8'hFF, 1'b1, 1'b1);
        rsp_latency(lat);
        check("div0_latency", 32'(lat), 32'd2);
        check("div0_alu_kept", 32'({bus.Alu_Op, bus.Alu_In1, bus.Alu_In2}), 32'hF_12_34);
        drain();
        check("op_count_6", 32'(op_count), 32'd6);

        // Backpressure: one in HOLD plus four queued; sixth refused.
        bus.Rsp_Ready = 1'b0;
        push(4'b0001, 8'h01, 8'h01, 8'h02, 1'b0, 1'b1);
        push(4'b0001, 8'h02, 8'h03, 8'h05, 1'b0, 1'b1);
        push(4'b0001, 8'h10, 8'h20, 8'h30, 1'b0, 1'b1);
        push(4'b0001, 8'hFF, 8'h01, 8'h00, 1'b0, 1'b1);
        push(4'b0011, 8'h0F, 8'h11, 8'hFF, 1'b0, 1'b1);
        bus.Cmd_Valid = 1'b1;
        bus.Cmd_Op    = 4'b0001;
        bus.Cmd_A     = 8'h77;
        bus.Cmd_B     = 8'h11;
        for (int i = 0; i < 4; i++) begin
            @(negedge Clk);
            check("full_refuses_6th", 32'(bus.Cmd_Ready), 32'd0);
        end
        check("hold_rsp_data", 32'({bus.Rsp_Valid, bus.Rsp_Data}), 32'h1_02);
        @(posedge Clk);
        #1 bus.Cmd_Valid = 1'b0;

        // Pop while full and offered: no push that cycle, ready rises next.
        bus.Cmd_Valid = 1'b1;
        bus.Cmd_Op    = 4'b0010;
        bus.Cmd_A     = 8'h09;
        bus.Cmd_B     = 8'h02;
        bus.Rsp_Ready = 1'b1;
        @(negedge Clk);
        check("full_at_handoff", 32'(bus.Cmd_Ready), 32'd0);
        @(posedge Clk);
        #1;
        @(negedge Clk);
        check("full_at_pop", 32'(bus.Cmd_Ready), 32'd0);
        @(posedge Clk);
        #1;
        @(negedge Clk);
        check("ready_after_pop", 32'(bus.Cmd_Ready), 32'd1);
        exp_q.push_back('{8'h07, 4'b0010, 1'b0});
        @(posedge Clk);
        #1 bus.Cmd_Valid = 1'b0;
        @(negedge Clk);
        check("full_after_push", 32'(bus.Cmd_Ready), 32'd0);
        drain();
        check("op_count_12", 32'(op_count), 32'd12);

        // Reset during ISSUE with two queued: everything dropped.
        push(4'b0001, 8'h01, 8'h01, 8'h02, 1'b0, 1'b0);
        push(4'b0001, 8'h02, 8'h02, 8'h04, 1'b0, 1'b0);
        push(4'b0001, 8'h03, 8'h03, 8'h06, 1'b0, 1'b0);
        Rst = 1'b1;
        @(posedge Clk);
        #1 Rst = 1'b0;
        @(negedge Clk);
        check("rst_rsp_valid", 32'(bus.Rsp_Valid), 32'd0);
        check("rst_cmd_ready", 32'(bus.Cmd_Ready), 32'd1);
        check("rst_op_count",  32'(op_count), 32'd0);
        stray = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge Clk);
            if (bus.Rsp_Valid !== 1'b0) stray++;
        end
        check("no_stray_after_rst", 32'(stray), 32'd0);
        @(posedge Clk);
        #1;

        push(4'b0001, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1);
        drain();
        check("op_count_after_rst", 32'(op_count), 32'd1);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
